// File: rtl/cpu_pkg.sv
// Shared MIPS-I encodings for the pipeline: opcodes, function codes, ALU ops, control bit indices.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    localparam int CTL_REG_WRITE   = 5;
    localparam int CTL_MEM_READ    = 4;
    localparam int CTL_MEM_WRITE   = 3;
    localparam int CTL_ALU_SRC_IMM = 2;
    localparam int CTL_BRANCH      = 1;
    localparam int CTL_JUMP        = 0;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Instruction field/control decoder: instr -> destination, immediate, ALU op, controls, rt usage.
// Latency: purely combinational.
// Backpressure: none; output follows the instruction word.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [3:0]  pc_hi,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [3:0]  alu_op,
    output logic [5:0]  ctl,
    output logic        uses_rt
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd_field;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [5:0]  raw_ctl;

    assign opcode   = instr[31:26];
    assign rt       = instr[20:16];
    assign rd_field = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm16    = instr[15:0];

    always_comb begin
        rd      = 5'd0;
        imm     = 32'd0;
        alu_op  = ALU_ADD;
        raw_ctl = 6'd0;
        uses_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rd      = rd_field;
                imm     = {27'd0, shamt};
                uses_rt = 1'b1;
                raw_ctl[CTL_REG_WRITE] = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_SRA:          alu_op = ALU_SRA;
                    FN_JR: begin
                        raw_ctl[CTL_REG_WRITE] = 1'b0;
                        raw_ctl[CTL_JUMP]      = 1'b1;
                    end
                    default: begin
                        rd      = 5'd0;
                        imm     = 32'd0;
                        uses_rt = 1'b0;
                        raw_ctl = 6'd0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                rd = rt;
                raw_ctl[CTL_REG_WRITE]   = 1'b1;
                raw_ctl[CTL_ALU_SRC_IMM] = 1'b1;
                imm = sext16(imm16);
                case (opcode)
                    OP_SLTI:  alu_op = ALU_SLT;
                    OP_SLTIU: alu_op = ALU_SLTU;
                    OP_ANDI:  begin alu_op = ALU_AND; imm = zext16(imm16); end
                    OP_ORI:   begin alu_op = ALU_OR;  imm = zext16(imm16); end
                    OP_XORI:  begin alu_op = ALU_XOR; imm = zext16(imm16); end
                    OP_LUI:   begin alu_op = ALU_LUI; imm = {imm16, 16'h0000}; end
                    default:  alu_op = ALU_ADD;
                endcase
            end
            OP_LW: begin
                rd  = rt;
                imm = sext16(imm16);
                raw_ctl[CTL_REG_WRITE]   = 1'b1;
                raw_ctl[CTL_MEM_READ]    = 1'b1;
                raw_ctl[CTL_ALU_SRC_IMM] = 1'b1;
            end
            OP_SW: begin
                rd      = rt;
                imm     = sext16(imm16);
                uses_rt = 1'b1;
                raw_ctl[CTL_MEM_WRITE]   = 1'b1;
                raw_ctl[CTL_ALU_SRC_IMM] = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                rd      = rt;
                imm     = sext16(imm16);
                alu_op  = ALU_SUB;
                uses_rt = 1'b1;
                raw_ctl[CTL_BRANCH] = 1'b1;
            end
            OP_J, OP_JAL: begin
                imm = {pc_hi, instr[25:0], 2'b00};
                raw_ctl[CTL_JUMP] = 1'b1;
                if (opcode == OP_JAL) begin
                    rd = 5'd31;
                    raw_ctl[CTL_REG_WRITE] = 1'b1;
                end
            end
            default: ;
        endcase
        // Writes to $0 are architecturally discarded, so never request them.
        ctl = raw_ctl;
        if (rd == 5'd0) begin
            ctl[CTL_REG_WRITE] = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: fetch handshake, regfile addressing, load-use bubble, ID/EX pipeline register.
// Latency: 1 cycle from acceptance to ID/EX outputs; regfile data aligned with them.
// Backpressure: if_ready drops on flush, EX stall (ex_valid && !ex_ready) or load-use hazard.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc,
    output logic              if_ready,
    input  logic              flush,
    output logic [REG_AW-1:0] addra,
    output logic [REG_AW-1:0] addrb,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_pc,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_imm,
    output logic [3:0]        ex_alu_op,
    output logic [5:0]        ex_ctl
);

    logic [REG_AW-1:0] dec_rd;
    logic [DATA_W-1:0] dec_imm;
    logic [3:0]        dec_alu_op;
    logic [5:0]        dec_ctl;
    logic              dec_uses_rt;

    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] held_rs;
    logic [REG_AW-1:0] held_rt;
    logic [REG_AW-1:0] last_load_rd;
    logic              stall_out;
    logic              hazard;
    logic              accept;

    instr_decoder u_instr_decoder (
        .instr   (if_instr),
        .pc_hi   (if_pc[DATA_W-1 -: 4]),
        .rd      (dec_rd),
        .imm     (dec_imm),
        .alu_op  (dec_alu_op),
        .ctl     (dec_ctl),
        .uses_rt (dec_uses_rt)
    );

    assign rs        = if_instr[25:21];
    assign rt        = if_instr[20:16];
    assign stall_out = ex_valid && !ex_ready;
    assign hazard    = if_valid && (last_load_rd != '0) &&
                       ((rs == last_load_rd) || (dec_uses_rt && (rt == last_load_rd)));
    assign if_ready  = !flush && !stall_out && !hazard;
    assign accept    = if_valid && if_ready;

    // While EX stalls the regfile must keep re-reading the operands of the ID/EX instruction.
    assign addra = (if_valid && !stall_out) ? rs : held_rs;
    assign addrb = (if_valid && !stall_out) ? rt : held_rt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rd        <= '0;
            ex_imm       <= '0;
            ex_alu_op    <= '0;
            ex_ctl       <= '0;
            held_rs      <= '0;
            held_rt      <= '0;
            last_load_rd <= '0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            last_load_rd <= '0;
        end else if (!stall_out) begin
            if (accept) begin
                ex_valid     <= 1'b1;
                ex_pc        <= if_pc;
                ex_rd        <= dec_rd;
                ex_imm       <= dec_imm;
                ex_alu_op    <= dec_alu_op;
                ex_ctl       <= dec_ctl;
                held_rs      <= rs;
                held_rt      <= rt;
                last_load_rd <= dec_ctl[CTL_MEM_READ] ? dec_rd : '0;
            end else begin
                // Idle or hazard bubble; clearing the load tag guarantees a single bubble.
                ex_valid     <= 1'b0;
                last_load_rd <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized checks of decode_stage against a transaction-level reference model.
module tb_decode_stage;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic [4:0]  addra;
    logic [4:0]  addrb;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic [31:0] ex_imm;
    logic [3:0]  ex_alu_op;
    logic [5:0]  ex_ctl;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [5:0]  ctl;
        logic        uses_rt;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } dec_t;

    decode_stage dut (
        .clock     (clock),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .if_ready  (if_ready),
        .flush     (flush),
        .addra     (addra),
        .addrb     (addrb),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_pc     (ex_pc),
        .ex_rd     (ex_rd),
        .ex_imm    (ex_imm),
        .ex_alu_op (ex_alu_op),
        .ex_ctl    (ex_ctl)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    // Reference decode written from the ISA description: {rw, mr, mw, imm_src, br, jmp}.
    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        dec_t d;
        logic rw, mr, mw, ai, br, jp;
        logic [31:0] s, z;
        s = {{16{ins[15]}}, ins[15:0]};
        z = {16'h0, ins[15:0]};
        {rw, mr, mw, ai, br, jp} = 6'b0;
        d = '0;
        d.pc = pc;
        d.rs = ins[25:21];
        d.rt = ins[20:16];
        d.alu = ALU_ADD;
        case (ins[31:26])
            OP_RTYPE: begin
                d.rd = ins[15:11]; d.imm = {27'd0, ins[10:6]}; d.uses_rt = 1'b1; rw = 1'b1;
                case (ins[5:0])
                    FN_ADD, FN_ADDU: d.alu = ALU_ADD;
                    FN_SUB, FN_SUBU: d.alu = ALU_SUB;
                    FN_AND: d.alu = ALU_AND;
                    FN_OR:  d.alu = ALU_OR;
                    FN_XOR: d.alu = ALU_XOR;
                    FN_NOR: d.alu = ALU_NOR;
                    FN_SLT: d.alu = ALU_SLT;
                    FN_SLTU: d.alu = ALU_SLTU;
                    FN_SLL: d.alu = ALU_SLL;
                    FN_SRL: d.alu = ALU_SRL;
                    FN_SRA: d.alu = ALU_SRA;
                    FN_JR: begin rw = 1'b0; jp = 1'b1; end
                    default: begin d.rd = 0; d.imm = 0; d.uses_rt = 0; rw = 0; end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin d.rd = ins[20:16]; d.imm = s; rw = 1; ai = 1; end
            OP_SLTI:  begin d.rd = ins[20:16]; d.imm = s; rw = 1; ai = 1; d.alu = ALU_SLT; end
            OP_SLTIU: begin d.rd = ins[20:16]; d.imm = s; rw = 1; ai = 1; d.alu = ALU_SLTU; end
            OP_ANDI:  begin d.rd = ins[20:16]; d.imm = z; rw = 1; ai = 1; d.alu = ALU_AND; end
            OP_ORI:   begin d.rd = ins[20:16]; d.imm = z; rw = 1; ai = 1; d.alu = ALU_OR; end
            OP_XORI:  begin d.rd = ins[20:16]; d.imm = z; rw = 1; ai = 1; d.alu = ALU_XOR; end
            OP_LUI:   begin d.rd = ins[20:16]; d.imm = {ins[15:0], 16'h0}; rw = 1; ai = 1;
                            d.alu = ALU_LUI; end
            OP_LW:    begin d.rd = ins[20:16]; d.imm = s; rw = 1; mr = 1; ai = 1; end
            OP_SW:    begin d.rd = ins[20:16]; d.imm = s; mw = 1; ai = 1; d.uses_rt = 1; end
            OP_BEQ, OP_BNE: begin d.rd = ins[20:16]; d.imm = s; br = 1; d.uses_rt = 1;
                                  d.alu = ALU_SUB; end
            OP_J:     begin d.imm = {pc[31:28], ins[25:0], 2'b00}; jp = 1; end
            OP_JAL:   begin d.imm = {pc[31:28], ins[25:0], 2'b00}; jp = 1; rw = 1; d.rd = 31; end
            default: ;
        endcase
        if (d.rd == 0) rw = 1'b0;
        d.ctl = {rw, mr, mw, ai, br, jp};
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  a, b, c;
        logic [15:0] im;
        logic [5:0]  fn;
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        c  = 5'($urandom_range(0, 7));
        im = 16'($urandom());
        case ($urandom_range(0, 6))
            0: fn = FN_ADD;
            1: fn = FN_SUB;
            2: fn = FN_OR;
            3: fn = FN_SLT;
            4: fn = FN_SRA;
            5: fn = FN_JR;
            default: fn = 6'h3F;
        endcase
        case ($urandom_range(0, 11))
            0, 1: return i_ins(OP_LW, a, b, im);
            2:  return i_ins(OP_SW, a, b, im);
            3:  return {6'h00, a, b, c, im[10:6], fn};
            4:  return i_ins(im[0] ? OP_BEQ : OP_BNE, a, b, im);
            5:  return i_ins(OP_ADDI, a, b, im);
            6:  return i_ins(OP_ORI, a, b, im);
            7:  return i_ins(OP_LUI, a, b, im);
            8:  return i_ins(im[1] ? OP_ANDI : OP_SLTIU, a, b, im);
            9:  return {OP_J, 26'($urandom())};
            10: return {OP_JAL, 26'($urandom())};
            default: return {6'h3F, a, b, im};
        endcase
    endfunction

    dec_t        ex_q[$];
    dec_t        d;
    logic [4:0]  lld_m;
    logic        v, rdy, fl, occ, stall, haz, exp_rdy;
    logic [31:0] ins, pcv;

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        ex_ready = 1'b1;
        flush = 1'b0;
        #12;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_ctl", 32'(ex_ctl), 32'd0);
        chk("rst_ex_rd", 32'(ex_rd), 32'd0);
        chk("rst_ex_imm", ex_imm, 32'd0);
        chk("rst_addra", 32'(addra), 32'd0);
        chk("rst_addrb", 32'(addrb), 32'd0);
        reset = 1'b1;
        cyc();

        // add $3,$1,$2
        drive(1'b1, 32'h00221820, 32'h100);
        @(negedge clock);
        chk("add_if_ready", 32'(if_ready), 32'd1);
        chk("add_addra", 32'(addra), 32'd1);
        chk("add_addrb", 32'(addrb), 32'd2);
        cyc();
        drive(1'b1, i_ins(OP_LW, 5'd1, 5'd5, 16'd4), 32'h104);
        @(negedge clock);
        chk("add_ex_valid", 32'(ex_valid), 32'd1);
        chk("add_ex_rd", 32'(ex_rd), 32'd3);
        chk("add_alu", 32'(ex_alu_op), 32'(ALU_ADD));
        chk("add_ctl", 32'(ex_ctl), 32'h20);
        chk("add_ex_pc", ex_pc, 32'h100);
        chk("lw_if_ready", 32'(if_ready), 32'd1);

        // load-use: lw $5 then add $6,$5,$2
        cyc();
        drive(1'b1, r_ins(FN_ADD, 5'd5, 5'd2, 5'd6), 32'h108);
        @(negedge clock);
        chk("haz_if_ready", 32'(if_ready), 32'd0);
        chk("haz_addra", 32'(addra), 32'd5);
        chk("lw_ex_rd", 32'(ex_rd), 32'd5);
        chk("lw_ctl", 32'(ex_ctl), 32'h34);
        chk("lw_imm", ex_imm, 32'd4);
        cyc();
        @(negedge clock);
        chk("bubble_ex_valid", 32'(ex_valid), 32'd0);
        chk("bubble_if_ready", 32'(if_ready), 32'd1);
        chk("bubble_addra", 32'(addra), 32'd5);
        cyc();
        drive(1'b1, i_ins(OP_LW, 5'd1, 5'd5, 16'd4), 32'h10C);
        @(negedge clock);
        chk("dep_ex_valid", 32'(ex_valid), 32'd1);
        chk("dep_ex_rd", 32'(ex_rd), 32'd6);
        chk("dep_ex_pc", ex_pc, 32'h108);
        cyc();
        drive(1'b1, r_ins(FN_ADD, 5'd7, 5'd2, 5'd6), 32'h110);
        @(negedge clock);
        chk("indep_if_ready", 32'(if_ready), 32'd1);
        cyc();
        drive(1'b1, r_ins(FN_SUB, 5'd8, 5'd9, 5'd4), 32'h114);
        @(negedge clock);
        chk("indep_ex_valid", 32'(ex_valid), 32'd1);
        chk("indep_ex_pc", ex_pc, 32'h110);

        // EX stall for three cycles
        cyc();
        ex_ready = 1'b0;
        drive(1'b1, r_ins(FN_OR, 5'd11, 5'd12, 5'd10), 32'h118);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_ex_valid", 32'(ex_valid), 32'd1);
            chk("stall_ex_pc", ex_pc, 32'h114);
            chk("stall_ex_rd", 32'(ex_rd), 32'd4);
            chk("stall_alu", 32'(ex_alu_op), 32'(ALU_SUB));
            chk("stall_if_ready", 32'(if_ready), 32'd0);
            chk("stall_addra", 32'(addra), 32'd8);
            chk("stall_addrb", 32'(addrb), 32'd9);
            cyc();
        end
        ex_ready = 1'b1;
        @(negedge clock);
        chk("unstall_if_ready", 32'(if_ready), 32'd1);
        chk("unstall_addra", 32'(addra), 32'd11);
        cyc();
        drive(1'b1, i_ins(OP_LW, 5'd1, 5'd5, 16'd4), 32'h11C);
        @(negedge clock);
        chk("or_ex_rd", 32'(ex_rd), 32'd10);
        chk("or_alu", 32'(ex_alu_op), 32'(ALU_OR));

        // flush with lw in ID/EX and dependent add waiting
        cyc();
        drive(1'b1, r_ins(FN_ADD, 5'd5, 5'd2, 5'd6), 32'h120);
        flush = 1'b1;
        @(negedge clock);
        chk("flush_if_ready", 32'(if_ready), 32'd0);
        cyc();
        flush = 1'b0;
        @(negedge clock);
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        chk("postflush_if_ready", 32'(if_ready), 32'd1);
        cyc();
        drive(1'b1, i_ins(OP_ADDIU, 5'd1, 5'd0, 16'hFFFF), 32'h124);
        @(negedge clock);
        chk("postflush_ex_valid", 32'(ex_valid), 32'd1);
        chk("postflush_ex_pc", ex_pc, 32'h120);

        // immediates and destination 0
        cyc();
        drive(1'b1, i_ins(OP_ORI, 5'd0, 5'd2, 16'hFFFF), 32'h128);
        @(negedge clock);
        chk("addiu0_ctl", 32'(ex_ctl), 32'h04);
        chk("addiu0_imm", ex_imm, 32'hFFFFFFFF);
        cyc();
        drive(1'b1, i_ins(OP_LUI, 5'd0, 5'd3, 16'hFFFF), 32'h12C);
        @(negedge clock);
        chk("ori_imm", ex_imm, 32'h0000FFFF);
        chk("ori_ctl", 32'(ex_ctl), 32'h24);
        cyc();
        drive(1'b1, {OP_JAL, 26'h0123456}, 32'hA0000000);
        @(negedge clock);
        chk("lui_imm", ex_imm, 32'hFFFF0000);
        chk("lui_alu", 32'(ex_alu_op), 32'(ALU_LUI));
        cyc();
        drive(1'b1, 32'hFC000000, 32'h130);
        @(negedge clock);
        chk("jal_rd", 32'(ex_rd), 32'd31);
        chk("jal_imm", ex_imm, 32'hA048D158);
        chk("jal_ctl", 32'(ex_ctl), 32'h21);
        cyc();
        drive(1'b1, 32'h0, 32'h134);
        @(negedge clock);
        chk("illegal_ex_valid", 32'(ex_valid), 32'd1);
        chk("illegal_ctl", 32'(ex_ctl), 32'd0);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clock);
        chk("nop_ex_valid", 32'(ex_valid), 32'd1);
        chk("nop_ctl", 32'(ex_ctl), 32'd0);

        // asynchronous reset while ID/EX is occupied
        reset = 1'b0;
        #1;
        chk("arst_ex_valid", 32'(ex_valid), 32'd0);
        chk("arst_ex_ctl", 32'(ex_ctl), 32'd0);
        chk("arst_ex_rd", 32'(ex_rd), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        cyc();

        // randomized traffic against the transaction-level model
        lld_m = 5'd0;
        for (int n = 0; n < 500; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            ins = rand_instr();
            pcv = $urandom();
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 24) == 0);
            drive(v, ins, pcv);
            ex_ready = rdy;
            flush    = fl;
            d     = ref_decode(ins, pcv);
            occ   = (ex_q.size() != 0);
            stall = occ && !rdy;
            haz   = v && (lld_m != 0) && (ins[25:21] == lld_m || (d.uses_rt && ins[20:16] == lld_m));
            exp_rdy = !fl && !stall && !haz;
            @(negedge clock);
            chk("rnd_if_ready", 32'(if_ready), 32'(exp_rdy));
            chk("rnd_ex_valid", 32'(ex_valid), 32'(occ));
            if (occ) begin
                chk("rnd_ex_pc", ex_pc, ex_q[0].pc);
                chk("rnd_ex_rd", 32'(ex_rd), 32'(ex_q[0].rd));
                chk("rnd_ex_imm", ex_imm, ex_q[0].imm);
                chk("rnd_ex_alu", 32'(ex_alu_op), 32'(ex_q[0].alu));
                chk("rnd_ex_ctl", 32'(ex_ctl), 32'(ex_q[0].ctl));
            end
            if (stall) begin
                chk("rnd_hold_addra", 32'(addra), 32'(ex_q[0].rs));
                chk("rnd_hold_addrb", 32'(addrb), 32'(ex_q[0].rt));
            end else if (v) begin
                chk("rnd_addra", 32'(addra), 32'(ins[25:21]));
                chk("rnd_addrb", 32'(addrb), 32'(ins[20:16]));
            end
            if (fl) begin
                ex_q.delete();
                lld_m = 5'd0;
            end else if (!stall) begin
                if (occ) void'(ex_q.pop_front());
                if (v && exp_rdy) begin
                    ex_q.push_back(d);
                    lld_m = d.ctl[4] ? d.rd : 5'd0;
                end else begin
                    lld_m = 5'd0;
                end
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
